zombie_wave_scheduler: RTL and testbench

//  Game sequencer for the lawn renderer. Owns the level FSM (I, L1, NL2, L2, NL3, L3, DoneL, DoneW).

---
 rtl/zombie_wave_scheduler_pkg.sv | 36 +++
 rtl/zombie_wave_scheduler_lfsr_lane_pick.sv | 23 ++
 rtl/zombie_wave_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_zombie_wave_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zombie_wave_scheduler_pkg.sv
// Shared constants, one-hot level state encoding and per-level helpers
// for the zombie wave scheduler and the lawn renderer.
package zombie_wave_scheduler_pkg;

   localparam int unsigned NUM_LANES = 5;
   localparam int unsigned LANE_W    = 3;
   localparam int unsigned X_W       = 10;

   localparam logic [X_W-1:0] X_START_DEFAULT = 10'd639;
   localparam logic [X_W-1:0] END_OF_LAWN     = 10'd0;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [7:0] {
      ST_I      = 8'b0000_0001,
      ST_L1     = 8'b0000_0010,
      ST_NL2    = 8'b0000_0100,
      ST_L2     = 8'b0000_1000,
      ST_NL3    = 8'b0001_0000,
      ST_L3     = 8'b0010_0000,
      ST_DONE_L = 8'b0100_0000,
      ST_DONE_W = 8'b1000_0000
   } state_t;

   function automatic logic [1:0] level_speed(input state_t s);
      case (s)
         ST_L1:   return 2'd1;
         ST_L2:   return 2'd2;
         ST_L3:   return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/zombie_wave_scheduler_lfsr_lane_pick.sv
// Free-running 8-bit Fibonacci LFSR; its value modulo the lane count
// selects the lane for the next spawn attempt.
module lfsr_lane_pick
   import zombie_wave_scheduler_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   output logic [LANE_W-1:0] lane
);

   logic [7:0] lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   assign lane = LANE_W'(lfsr % 8'(NUM_LANES));

endmodule

// File: rtl/zombie_wave_scheduler.sv
// Game sequencer: level FSM, move-tick divider, per-lane zombie spawn/move
// and kill accounting for the lawn renderer. All outputs are registered.
module zombie_wave_scheduler
   import zombie_wave_scheduler_pkg::*;
#(
   parameter int unsigned    MOVE_DIV    = 500000,
   parameter int unsigned    SPAWN_TICKS = 64,
   parameter logic [X_W-1:0] X_START     = X_START_DEFAULT,
   parameter int unsigned    QUOTA_L1    = 5,
   parameter int unsigned    QUOTA_L2    = 10,
   parameter int unsigned    QUOTA_L3    = 15,
   parameter int unsigned    PAUSE_TICKS = 128
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     kill_valid,
   input  logic [LANE_W-1:0]        kill_lane,
   output logic [NUM_LANES-1:0]     zombie_active,
   output logic [NUM_LANES*X_W-1:0] zombie_x,
   output logic [15:0]              zombies_killed,
   output logic                     move_tick,
   output logic                     q_I,
   output logic                     q_L1,
   output logic                     q_NL2,
   output logic                     q_L2,
   output logic                     q_NL3,
   output logic                     q_L3,
   output logic                     q_DoneL,
   output logic                     q_DoneW
);

   localparam int unsigned DIV_W   = (MOVE_DIV > 1)    ? $clog2(MOVE_DIV)    : 1;
   localparam int unsigned SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
   localparam int unsigned PAUSE_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(MOVE_DIV - 1);
   localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_TICKS - 1);
   localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);

   state_t               state;
   state_t               state_nxt;
   logic [DIV_W-1:0]     div_cnt;
   logic [SPAWN_W-1:0]   spawn_cnt;
   logic [PAUSE_W-1:0]   pause_cnt;
   logic [7:0]           level_kills;
   logic [7:0]           quota;
   logic [1:0]           speed;
   logic [LANE_W-1:0]    pick_lane;
   logic [NUM_LANES-1:0] lane_lost;

   logic in_level;
   logic in_pause;
   logic start_game;
   logic kill_hit;
   logic quota_hit;
   logic advance;
   logic spawn_due;
   logic pause_done;
   logic lost;

   lfsr_lane_pick u_pick (
      .clk     (clk),
      .reset_n (reset_n),
      .lane    (pick_lane)
   );

   always_comb begin
      quota = 8'(QUOTA_L3);
      case (state)
         ST_L1:   quota = 8'(QUOTA_L1);
         ST_L2:   quota = 8'(QUOTA_L2);
         default: quota = 8'(QUOTA_L3);
      endcase
   end

   assign speed      = level_speed(state);
   assign in_level   = (state == ST_L1) || (state == ST_L2) || (state == ST_L3);
   assign in_pause   = (state == ST_NL2) || (state == ST_NL3);
   assign start_game = (state == ST_I) && start;
   assign kill_hit   = in_level && kill_valid && (kill_lane < LANE_W'(NUM_LANES))
                       && zombie_active[kill_lane];
   assign quota_hit  = kill_hit && ((level_kills + 8'd1) == quota);
   // A quota-completing kill ends the level before any move or loss check.
   assign advance    = in_level && move_tick && !quota_hit;
   assign spawn_due  = advance && (spawn_cnt == SPAWN_LAST);
   assign pause_done = in_pause && (start || (move_tick && (pause_cnt == PAUSE_LAST)));
   assign lost       = |lane_lost;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_I:      if (start) state_nxt = ST_L1;
         ST_L1:     if (quota_hit) state_nxt = ST_NL2;
                    else if (lost) state_nxt = ST_DONE_L;
         ST_NL2:    if (pause_done) state_nxt = ST_L2;
         ST_L2:     if (quota_hit) state_nxt = ST_NL3;
                    else if (lost) state_nxt = ST_DONE_L;
         ST_NL3:    if (pause_done) state_nxt = ST_L3;
         ST_L3:     if (quota_hit) state_nxt = ST_DONE_W;
                    else if (lost) state_nxt = ST_DONE_L;
         ST_DONE_L: if (start) state_nxt = ST_I;
         ST_DONE_W: if (start) state_nxt = ST_I;
         default:   state_nxt = ST_I;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_I;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         move_tick <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt   <= '0;
         move_tick <= 1'b1;
      end else begin
         div_cnt   <= div_cnt + DIV_W'(1);
         move_tick <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spawn_cnt <= '0;
         pause_cnt <= '0;
      end else begin
         if (start_game || quota_hit) begin
            spawn_cnt <= '0;
         end else if (advance) begin
            spawn_cnt <= spawn_due ? '0 : spawn_cnt + SPAWN_W'(1);
         end
         if (pause_done) begin
            pause_cnt <= '0;
         end else if (in_pause && move_tick) begin
            pause_cnt <= pause_cnt + PAUSE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zombies_killed <= '0;
         level_kills    <= '0;
      end else if (start_game) begin
         zombies_killed <= '0;
         level_kills    <= '0;
      end else if (kill_hit) begin
         if (zombies_killed != 16'hFFFF) begin
            zombies_killed <= zombies_killed + 16'd1;
         end
         level_kills <= quota_hit ? '0 : level_kills + 8'd1;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [X_W-1:0] x;
      logic           active;
      logic           killed_here;
      logic           spawn_here;

      // Spawn only into a lane that was free before this edge, so a same-cycle
      // kill retires the old zombie and the spawn is dropped.
      assign killed_here  = kill_hit && (kill_lane == LANE_W'(g));
      assign spawn_here   = spawn_due && (pick_lane == LANE_W'(g)) && !active;
      assign lane_lost[g] = advance && active && !killed_here
                            && (x <= END_OF_LAWN + X_W'(speed));

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            x      <= X_START;
            active <= 1'b0;
         end else if (start_game) begin
            x      <= X_START;
            active <= 1'b0;
         end else if (quota_hit || killed_here) begin
            active <= 1'b0;
         end else if (spawn_here) begin
            x      <= X_START;
            active <= 1'b1;
         end else if (advance && active) begin
            x <= lane_lost[g] ? '0 : x - X_W'(speed);
         end
      end

      assign zombie_active[g]       = active;
      assign zombie_x[g*X_W +: X_W] = x;
   end

   assign q_I     = state[0];
   assign q_L1    = state[1];
   assign q_NL2   = state[2];
   assign q_L2    = state[3];
   assign q_NL3   = state[4];
   assign q_L3    = state[5];
   assign q_DoneL = state[6];
   assign q_DoneW = state[7];

endmodule

// File: tb/tb_zombie_wave_scheduler.sv
// Bench for zombie_wave_scheduler: directed table, corner sequences and
// random play, all compared against a game-rule reference model.
module tb_zombie_wave_scheduler;

   localparam int DIV = 4;
   localparam int SPW = 2;
   localparam int PAU = 3;
   localparam int XS  = 20;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        kill_valid;
   logic [2:0]  kill_lane;
   logic [4:0]  zombie_active;
   logic [49:0] zombie_x;
   logic [15:0] zombies_killed;
   logic        move_tick;
   logic        q_I, q_L1, q_NL2, q_L2, q_NL3, q_L3, q_DoneL, q_DoneW;
   logic [7:0]  q_bus;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: level index 0..7 = I,L1,NL2,L2,NL3,L3,DoneL,DoneW
   int       m_state, m_div, m_spawn, m_pause, m_killed, m_lk;
   bit       m_tick;
   bit [4:0] m_act;
   int       m_x[5];
   bit [7:0] m_lfsr;

   zombie_wave_scheduler #(
      .MOVE_DIV    (DIV),
      .SPAWN_TICKS (SPW),
      .X_START     (10'(XS)),
      .PAUSE_TICKS (PAU)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .kill_valid     (kill_valid),
      .kill_lane      (kill_lane),
      .zombie_active  (zombie_active),
      .zombie_x       (zombie_x),
      .zombies_killed (zombies_killed),
      .move_tick      (move_tick),
      .q_I            (q_I),
      .q_L1           (q_L1),
      .q_NL2          (q_NL2),
      .q_L2           (q_L2),
      .q_NL3          (q_NL3),
      .q_L3           (q_L3),
      .q_DoneL        (q_DoneL),
      .q_DoneW        (q_DoneW)
   );

   assign q_bus = {q_DoneW, q_DoneL, q_L3, q_NL3, q_L2, q_NL2, q_L1, q_I};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_div = 0; m_spawn = 0; m_pause = 0;
      m_killed = 0; m_lk = 0; m_tick = 0; m_act = '0; m_lfsr = 8'hA5;
      foreach (m_x[i]) m_x[i] = XS;
   endtask

   task automatic model_step(input bit st, input bit kv, input int kl);
      int       speed, quota, pick, nxt;
      bit       lvl, kill_ok, quota_hit, lost;
      bit [4:0] act_n;
      int       x_n[5];
      lvl   = (m_state == 1) || (m_state == 3) || (m_state == 5);
      speed = (m_state == 1) ? 1 : (m_state == 3) ? 2 : 3;
      quota = (m_state == 1) ? 5 : (m_state == 3) ? 10 : 15;
      pick  = int'(m_lfsr) % 5;
      kill_ok = 1'b0;
      if (lvl && kv && kl < 5) kill_ok = m_act[kl];
      quota_hit = kill_ok && (m_lk + 1 == quota);
      act_n = m_act; x_n = m_x; nxt = m_state; lost = 1'b0;
      if (m_state == 0) begin
         if (st) begin
            nxt = 1; m_killed = 0; m_lk = 0; m_spawn = 0; act_n = '0;
            foreach (x_n[i]) x_n[i] = XS;
         end
      end else if (lvl) begin
         if (kill_ok) begin
            act_n[kl] = 1'b0;
            if (m_killed < 65535) m_killed++;
            m_lk++;
         end
         if (quota_hit) begin
            act_n = '0; m_lk = 0; m_spawn = 0;
            nxt = (m_state == 5) ? 7 : m_state + 1;
         end else if (m_tick) begin
            for (int i = 0; i < 5; i++) begin
               if (m_act[i] && !(kill_ok && kl == i)) begin
                  if (m_x[i] <= speed) begin x_n[i] = 0; lost = 1'b1; end
                  else x_n[i] = m_x[i] - speed;
               end
            end
            if (m_spawn == SPW - 1) begin
               m_spawn = 0;
               if (!m_act[pick]) begin act_n[pick] = 1'b1; x_n[pick] = XS; end
            end else m_spawn++;
            if (lost) nxt = 6;
         end
      end else if (m_state == 2 || m_state == 4) begin
         if (st || (m_tick && m_pause == PAU - 1)) begin nxt = m_state + 1; m_pause = 0; end
         else if (m_tick) m_pause++;
      end else if (st) begin
         nxt = 0;
      end
      m_tick = (m_div == DIV - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      m_state = nxt; m_act = act_n; m_x = x_n;
   endtask

   task automatic check_model(input string tag);
      logic [49:0] xv;
      for (int i = 0; i < 5; i++) xv[i*10 +: 10] = 10'(m_x[i]);
      chk({tag, " state"}, 64'(q_bus), 64'(1) << m_state);
      chk({tag, " active"}, 64'(zombie_active), 64'(m_act));
      chk({tag, " x"}, 64'(zombie_x), 64'(xv));
      chk({tag, " killed"}, 64'(zombies_killed), 64'(m_killed));
      chk({tag, " tick"}, 64'(move_tick), 64'(m_tick));
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input bit st, input bit kv, input logic [2:0] kl, input string tag);
      start = st; kill_valid = kv; kill_lane = kl;
      @(posedge clk);
      model_step(st, kv, int'(kl));
      #1 check_model(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0; start = 1'b0; kill_valid = 1'b0;
      #1 model_reset();
      check_model("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic play_kills(input int target, input string tag);
      int budget = 3000;
      int lane;
      while (m_killed < target && budget > 0) begin
         lane = -1;
         for (int i = 4; i >= 0; i--) if (m_act[i]) lane = i;
         if (lane >= 0 && (m_state == 1 || m_state == 3 || m_state == 5))
            step(1'b0, 1'b1, 3'(lane), tag);
         else
            step(1'b0, 1'b0, 3'd0, tag);
         budget--;
      end
      chk({tag, " reached"}, 64'(zombies_killed), 64'(target));
   endtask

   typedef struct {
      bit         st;
      bit         kv;
      logic [2:0] kl;
      logic [7:0] exp_q;
      int         exp_killed;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int n, budget, found;
      bit [4:0] frozen;

      tbl[0] = '{1'b0, 1'b0, 3'd0, 8'h01, 0};  // idle in I
      tbl[1] = '{1'b0, 1'b1, 3'd2, 8'h01, 0};  // kill ignored in I
      tbl[2] = '{1'b1, 1'b0, 3'd0, 8'h02, 0};  // start -> L1
      tbl[3] = '{1'b0, 1'b1, 3'd6, 8'h02, 0};  // out-of-range lane
      tbl[4] = '{1'b0, 1'b1, 3'd7, 8'h02, 0};
      tbl[5] = '{1'b0, 1'b1, 3'd0, 8'h02, 0};  // lane not yet occupied
      tbl[6] = '{1'b1, 1'b0, 3'd0, 8'h02, 0};  // start ignored in a level

      reset_n = 1'b0; start = 1'b0; kill_valid = 1'b0; kill_lane = '0;
      repeat (2) @(posedge clk);
      #1 model_reset();
      check_model("por");
      chk("por q_I", 64'(q_I), 64'd1);
      chk("por x0", 64'(zombie_x[9:0]), 64'(XS));
      @(negedge clk);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].kv, tbl[i].kl, "table");
         chk($sformatf("table[%0d] q", i), 64'(q_bus), 64'(tbl[i].exp_q));
         chk($sformatf("table[%0d] killed", i), 64'(zombies_killed), 64'(tbl[i].exp_killed));
      end

      // L1 quota, pause of PAUSE ticks, then reset mid-L2
      do_reset();
      step(1'b1, 1'b0, 3'd0, "l1_start");
      play_kills(5, "l1_quota");
      chk("l1_quota q_NL2", 64'(q_bus), 64'h04);
      chk("l1_quota active", 64'(zombie_active), 64'd0);
      n = move_tick ? 1 : 0;
      budget = 100;
      while (n < PAU && budget > 0) begin
         step(1'b0, 1'b0, 3'd0, "pause");
         if (move_tick) n++;
         budget--;
      end
      chk("pause last tick still NL2", 64'(q_bus), 64'h04);
      step(1'b0, 1'b0, 3'd0, "pause_exit");
      chk("pause exit q_L2", 64'(q_bus), 64'h08);
      budget = 300;
      while ($countones(m_act) < 3 && m_state == 3 && budget > 0) begin
         step(1'b0, 1'b0, 3'd0, "l2_fill");
         budget--;
      end
      do_reset();
      chk("mid_l2 reset q_I", 64'(q_bus), 64'h01);
      chk("mid_l2 reset active", 64'(zombie_active), 64'd0);
      chk("mid_l2 reset killed", 64'(zombies_killed), 64'd0);
      chk("mid_l2 reset tick", 64'(move_tick), 64'd0);

      // no kills: first zombie walks off the lawn
      step(1'b1, 1'b0, 3'd0, "loss_start");
      budget = 500;
      while (m_state != 6 && budget > 0) begin
         step(1'b0, 1'b0, 3'd0, "loss_walk");
         budget--;
      end
      chk("loss q_DoneL", 64'(q_bus), 64'h40);
      frozen = m_act;
      repeat (20) step(1'b0, 1'b1, 3'd0, "frozen");
      chk("frozen active", 64'(zombie_active), 64'(frozen));
      step(1'b1, 1'b0, 3'd0, "loss_restart");
      chk("loss restart q_I", 64'(q_bus), 64'h01);

      // kill lane 3 on the move_tick cycle where it sits at x=1
      found = 0;
      for (int a = 0; a < 40 && !found; a++) begin
         do_reset();
         repeat (a) step(1'b0, 1'b0, 3'd0, "seek_wait");
         step(1'b1, 1'b0, 3'd0, "seek_start");
         budget = 40;
         while (m_act == 0 && budget > 0) begin
            step(1'b0, 1'b0, 3'd0, "seek_spawn");
            budget--;
         end
         if (m_act == 5'b01000) found = 1;
      end
      chk("lane3 first spawn found", 64'(found), 64'd1);
      budget = 200;
      while (!(m_tick && m_act[3] && m_x[3] == 1) && budget > 0) begin
         step(1'b0, 1'b0, 3'd0, "lane3_walk");
         budget--;
      end
      chk("lane3 x=1 on tick", 64'(zombie_x[39:30]), 64'd1);
      step(1'b0, 1'b1, 3'd3, "lane3_kill");
      chk("kill beats tick q_L1", 64'(q_bus), 64'h02);
      chk("kill beats tick lane3", 64'(zombie_active[3]), 64'd0);
      chk("kill beats tick x3", 64'(zombie_x[39:30]), 64'd1);
      chk("kill beats tick count", 64'(zombies_killed), 64'd1);

      // full game to a win, start-skip of the NL3 pause, restart
      do_reset();
      step(1'b1, 1'b0, 3'd0, "win_start");
      play_kills(15, "to_nl3");
      chk("to_nl3 q_NL3", 64'(q_bus), 64'h10);
      step(1'b1, 1'b0, 3'd0, "nl3_start");
      chk("nl3 start q_L3", 64'(q_bus), 64'h20);
      play_kills(30, "l3_quota");
      chk("win q_DoneW", 64'(q_bus), 64'h80);
      chk("win active", 64'(zombie_active), 64'd0);
      repeat (10) step(1'b0, 1'b1, 3'd1, "win_hold");
      chk("win held killed", 64'(zombies_killed), 64'd30);
      step(1'b1, 1'b0, 3'd0, "win_to_i");
      chk("win to I q_I", 64'(q_bus), 64'h01);
      chk("win to I killed held", 64'(zombies_killed), 64'd30);
      step(1'b1, 1'b0, 3'd0, "new_game");
      chk("new game q_L1", 64'(q_bus), 64'h02);
      chk("new game killed", 64'(zombies_killed), 64'd0);

      // random play
      for (int c = 0; c < 3000; c++) begin
         bit st, kv;
         logic [2:0] kl;
         if ($urandom_range(0, 599) == 0) do_reset();
         st = ($urandom_range(0, 29) == 0);
         kv = ($urandom_range(0, 2) == 0);
         kl = 3'($urandom_range(0, 7));
         step(st, kv, kl, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
